wave_gen_multi: RTL and testbench
=================================

// Module: wave_gen_multi
// PURPOSE
//  Multi-channel programmable waveform generator. Successor to the single-channel fixed-table square generator.
//  Each channel is configured at runtime with mode, period and duty.
//  New settings go to a shadow copy and are applied glitch-free at the channel's next period boundary.
//  Sits between the control/register front-end (cfg handshake) and the signal output pins.
// PARAMETERS
//  NUM_CH   4   number of independent channels
//  CNT_W    21  width of period/duty values and per-channel phase counter
//  CH_W     $clog2(NUM_CH) (min 1)  width of channel select
// PORTS
//  clk          in   1          single clock; all logic on posedge
//  reset_n      in   1          synchronous, active-low reset
//  cfg_valid    in   1          config request valid
//  cfg_ready    out  1          = ~pending[cfg_ch] (1 for out-of-range cfg_ch)
//  cfg_ch       in   CH_W       target channel
//  cfg_mode     in   2          wg_mode_t: OFF / SQUARE / PWM / ONESHOT
//  cfg_period   in   CNT_W      period P in clk cycles
//  cfg_duty     in   CNT_W      high cycles per period (PWM, ONESHOT)
//  cfg_err      out  1          1-cycle pulse: handshake with cfg_ch >= NUM_CH
//  wave         out  NUM_CH     registered waveform outputs
//  period_tick  out  NUM_CH     1-cycle pulse on first cycle of each period
//  done         out  NUM_CH     1-cycle pulse when a ONESHOT completes
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - all channels active mode OFF; pending=0; phase=0.
//   - wave, period_tick, done and cfg_err are 0; cfg_ready=1.
//  Handshake:
//   - Transfer occurs at a posedge with cfg_valid & cfg_ready.
//   - The transfer loads the shadow {mode, P, duty} of cfg_ch and sets pending.
//   - Out-of-range cfg_ch: the transfer is dropped and cfg_err pulses on the next cycle.
//  Effective values:
//   - Peff = max(P,2).
//   - H (high count): SQUARE = Peff>>1; PWM, ONESHOT = min(duty,Peff); OFF = 0.
//  Apply: at a posedge where pending=1 and (active mode OFF, or phase==Peff_active-1):
//   - shadow is copied to active; phase<=0; pending<=0.
//   - For a running channel this edge is the normal wrap edge, so no truncated or stretched period ever appears.
//  Latency:
//   - Channel OFF: the apply edge is the edge after the transfer, so wave can first rise 2 cycles after the handshake edge.
//   - Channel running: the new setting starts on the first cycle after the current period ends.
//  Run:
//   - When not OFF, phase increments each cycle and wraps to 0 at Peff-1.
//   - wave=1 while phase<H; wave is registered with no combinational path from any input.
//   - period_tick=1 on cycles where phase==0 and mode!=OFF.
//  Boundary cases:
//   - duty=0: wave stays 0.
//   - duty>=Peff (PWM): wave stays 1, and period_tick still pulses every Peff cycles.
//   - P<2 is clamped to 2.
//  ONESHOT:
//   - Runs exactly one period.
//   - At its wrap edge the active mode becomes OFF, unless pending, in which case the shadow applies.
//   - done pulses on the cycle after the wrap.
//  OFF:
//   - wave=0; phase held at 0.
//   - A transfer to OFF on a running channel also waits for the boundary, so stopping is glitch-free.
//  Back-pressure:
//   - At most one pending update per channel; while it is pending, cfg_ready=0 for that channel.
//   - Other channels accept transfers independently.
//  Simultaneous events:
//   - Apply and a new transfer cannot hit the same channel in one cycle, because ready=0 while pending.
//   - Applies on different channels in the same cycle are independent.
//  Reset mid-operation: a synchronous return to the reset state on that edge; pending updates are discarded.
// STRUCTURE
//  Package wave_gen_pkg:
//   - typedef enum logic [1:0] wg_mode_t {WG_OFF, WG_SQUARE, WG_PWM, WG_ONESHOT}.
//   - localparam MIN_PERIOD = 2.
//  Sub-module wave_gen_channel: one channel (shadow, pending, active regs, phase counter, wave/tick/done flops).
//  Top level: generate loop over NUM_CH, cfg_ch decode, cfg_ready mux, cfg_err flop.
// TESTING
//  - ch0 SQUARE P=4 from OFF: wave 1100 repeating, starting 2 cycles after the handshake; period_tick every 4.
//  - ch1 PWM P=10 d=3 running; PWM P=6 d=6 sent at phase 4:
//    - the current period finishes as 3 high / 7 low;
//    - then wave stays 1 and period_tick pulses every 6 cycles.
//  - Back-pressure: a second transfer to ch1 while pending sees cfg_ready=0 until the apply edge.
//    A transfer to ch2 in the same cycle is accepted.
//  - ch3 ONESHOT P=8 d=5: exactly 5 high + 3 low cycles, done pulses once, then wave stays 0 and period_tick stops.
//  - cfg_ch=5 with NUM_CH=4: no channel changes; cfg_err is a single 1-cycle pulse.
//  - reset_n low mid-period on all channels:
//    - next cycle wave=0, period_tick=0, cfg_ready=1;
//    - a pending update is lost (no apply after release).

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the multi-channel waveform generator.
//   wg_mode_t  : per-channel operating mode
//   MIN_PERIOD : smallest effective period; shorter requests are clamped up
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WG_OFF     = 2'd0,
    WG_SQUARE  = 2'd1,
    WG_PWM     = 2'd2,
    WG_ONESHOT = 2'd3
  } wg_mode_t;

  localparam int MIN_PERIOD = 2;

  // True for every mode in which the phase counter advances.
  function automatic logic is_running(input wg_mode_t m);
    return (m != WG_OFF);
  endfunction

endpackage

// File: rtl/wave_gen_channel.sv
// One waveform channel: shadow config, pending flag, active config,
// phase counter and registered wave / period_tick / done outputs.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   load            accepted config transfer addressed to this channel
//   cfg_mode/period/duty  config payload captured into the shadow on load
//   pending         shadow holds an update not yet applied
//   wave            registered waveform output
//   period_tick     1-cycle pulse on the first output cycle of each period
//   done            1-cycle pulse when a ONESHOT period finishes
//
// The outputs are flops fed from the current phase, so each output cycle
// reflects the phase of the previous cycle. This keeps every output free
// of any combinational path from the inputs.
module wave_gen_channel
  import wave_gen_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  wg_mode_t         cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pending,
  output logic             wave,
  output logic             period_tick,
  output logic             done
);

  localparam logic [CNT_W-1:0] PMIN = CNT_W'(MIN_PERIOD);

  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
    return (p < PMIN) ? PMIN : p;
  endfunction

  function automatic logic [CNT_W-1:0] high_count(input wg_mode_t m,
                                                  input logic [CNT_W-1:0] p,
                                                  input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] pe;
    pe = eff_period(p);
    case (m)
      WG_SQUARE:  return pe >> 1;
      WG_PWM,
      WG_ONESHOT: return (d < pe) ? d : pe;
      default:    return '0;
    endcase
  endfunction

  // shadow copy
  wg_mode_t         sh_mode,   nx_sh_mode;
  logic [CNT_W-1:0] sh_period, nx_sh_period;
  logic [CNT_W-1:0] sh_duty,   nx_sh_duty;
  logic             pend_q,    nx_pend;

  // active copy, stored already reduced to effective period and high count
  wg_mode_t         act_mode,  nx_mode;
  logic [CNT_W-1:0] act_peff,  nx_peff;
  logic [CNT_W-1:0] act_h,     nx_h;
  logic [CNT_W-1:0] phase,     nx_phase;

  logic wave_q, nx_wave;
  logic tick_q, nx_tick;
  logic done_q, nx_done;

  logic running;
  logic at_wrap;

  always_comb begin
    nx_sh_mode   = sh_mode;
    nx_sh_period = sh_period;
    nx_sh_duty   = sh_duty;
    nx_pend      = pend_q;
    nx_mode      = act_mode;
    nx_peff      = act_peff;
    nx_h         = act_h;
    nx_phase     = phase;

    running = is_running(act_mode);
    at_wrap = running && (phase == act_peff - CNT_W'(1));

    nx_wave = running && (phase < act_h);
    nx_tick = running && (phase == '0);
    nx_done = (act_mode == WG_ONESHOT) && at_wrap;

    // An update lands either immediately on an idle channel or on the
    // wrap edge of a running one, so periods are never cut or stretched.
    if (pend_q && (!running || at_wrap)) begin
      nx_mode  = sh_mode;
      nx_peff  = eff_period(sh_period);
      nx_h     = high_count(sh_mode, sh_period, sh_duty);
      nx_phase = '0;
      nx_pend  = 1'b0;
    end else if (at_wrap) begin
      nx_phase = '0;
      if (act_mode == WG_ONESHOT) nx_mode = WG_OFF;
    end else if (running) begin
      nx_phase = phase + CNT_W'(1);
    end

    // load never coincides with an apply: the top only loads when not pending
    if (load) begin
      nx_sh_mode   = cfg_mode;
      nx_sh_period = cfg_period;
      nx_sh_duty   = cfg_duty;
      nx_pend      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_mode   <= WG_OFF;
      sh_period <= '0;
      sh_duty   <= '0;
      pend_q    <= 1'b0;
      act_mode  <= WG_OFF;
      act_peff  <= PMIN;
      act_h     <= '0;
      phase     <= '0;
      wave_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sh_mode   <= nx_sh_mode;
      sh_period <= nx_sh_period;
      sh_duty   <= nx_sh_duty;
      pend_q    <= nx_pend;
      act_mode  <= nx_mode;
      act_peff  <= nx_peff;
      act_h     <= nx_h;
      phase     <= nx_phase;
      wave_q    <= nx_wave;
      tick_q    <= nx_tick;
      done_q    <= nx_done;
    end
  end

  assign pending     = pend_q;
  assign wave        = wave_q;
  assign period_tick = tick_q;
  assign done        = done_q;

endmodule

// File: rtl/wave_gen_multi.sv
// Multi-channel programmable waveform generator.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   cfg_valid      config request valid
//   cfg_ready      0 only while the addressed channel already has a pending update
//   cfg_ch         target channel (values >= NUM_CH are dropped with cfg_err)
//   cfg_mode       OFF / SQUARE / PWM / ONESHOT
//   cfg_period     period in clk cycles (clamped to at least 2)
//   cfg_duty       high cycles per period for PWM / ONESHOT
//   cfg_err        1-cycle pulse after a transfer to an out-of-range channel
//   wave           registered waveform per channel
//   period_tick    per-channel pulse on the first cycle of each period
//   done           per-channel pulse when a ONESHOT completes
//
// Handshake: a transfer happens on a posedge where cfg_valid and cfg_ready
// are both 1. cfg_ready depends only on cfg_ch and internal state, never on
// cfg_valid. Payload must be held while cfg_valid=1 and cfg_ready=0.
module wave_gen_multi
  import wave_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 21,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  wg_mode_t          cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] wave,
  output logic [NUM_CH-1:0] period_tick,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic              in_range;
  logic              err_q;

  // channel decode: out-of-range selects stay ready so the request is
  // consumed (and flagged) rather than stalling the front-end
  always_comb begin
    in_range  = 1'b0;
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        in_range  = 1'b1;
        cfg_ready = ~pending[i];
        load[i]   = cfg_valid & ~pending[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= cfg_valid & ~in_range;
  end

  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wave_gen_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (load[g]),
      .cfg_mode    (cfg_mode),
      .cfg_period  (cfg_period),
      .cfg_duty    (cfg_duty),
      .pending     (pending[g]),
      .wave        (wave[g]),
      .period_tick (period_tick[g]),
      .done        (done[g])
    );
  end

endmodule

// File: tb/tb_wave_gen_multi.sv
module tb_wave_gen_multi;
  import wave_gen_pkg::*;

  localparam int NCH  = 4;
  localparam int CW   = 21;
  localparam int CHW  = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  wg_mode_t       cfg_mode = WG_OFF;
  logic [CW-1:0]  cfg_period = '0;
  logic [CW-1:0]  cfg_duty = '0;
  logic           cfg_err;
  logic [NCH-1:0] wave, period_tick, done;

  wave_gen_multi #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .wave(wave), .period_tick(period_tick), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by the cycle its current setting started
  // (age = cycles since then); phase is age modulo the effective period.
  int m_mode[NCH], m_peff[NCH], m_h[NCH], m_age[NCH];
  bit m_pend[NCH];
  int s_mode[NCH], s_p[NCH], s_d[NCH];
  logic [NCH-1:0] e_wave = '0, e_tick = '0, e_done = '0;
  logic           e_err = 1'b0;

  function automatic int peff_of(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int h_of(input int md, input int p, input int d);
    int pe;
    pe = peff_of(p);
    if (md == 1) return pe / 2;
    if (md == 2 || md == 3) return (d < pe) ? d : pe;
    return 0;
  endfunction

  function automatic bit model_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_step(input bit rst_n, input bit v, input int ch,
                            input int md, input int p, input int d);
    bit acc, run, last;
    int ph;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_peff[c] = 2; m_h[c] = 0; m_age[c] = 0; m_pend[c] = 0;
      end
      e_wave = '0; e_tick = '0; e_done = '0; e_err = 1'b0;
      return;
    end
    acc   = v && model_ready(ch);
    e_err = v && (ch >= NCH);
    for (int c = 0; c < NCH; c++) begin
      run  = (m_mode[c] != 0);
      ph   = run ? (m_age[c] % m_peff[c]) : 0;
      last = run && (ph == m_peff[c] - 1);
      e_wave[c] = run && (ph < m_h[c]);
      e_tick[c] = run && (ph == 0);
      e_done[c] = (m_mode[c] == 3) && last;
      if (m_pend[c] && (!run || last)) begin
        m_mode[c] = s_mode[c];
        m_peff[c] = peff_of(s_p[c]);
        m_h[c]    = h_of(s_mode[c], s_p[c], s_d[c]);
        m_age[c]  = 0;
        m_pend[c] = 0;
      end else if (run) begin
        if (m_mode[c] == 3 && last) begin
          m_mode[c] = 0;
          m_age[c]  = 0;
        end else begin
          m_age[c]++;
        end
      end
    end
    if (acc && ch < NCH) begin
      m_pend[ch] = 1;
      s_mode[ch] = md; s_p[ch] = p; s_d[ch] = d;
    end
  endtask

  // ---------------- driver ----------------
  logic [NCH-1:0] obs_wave, obs_done;
  logic           obs_err;

  // Called at a negedge: drive inputs, check ready, advance one clock,
  // then compare all registered outputs against the model.
  task automatic tick(input bit rst_n, input bit v, input int ch,
                      input int md, input int p, input int d);
    reset_n    = rst_n;
    cfg_valid  = v;
    cfg_ch     = CHW'(ch);
    cfg_mode   = wg_mode_t'(md);
    cfg_period = CW'(p);
    cfg_duty   = CW'(d);
    #1;
    chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, model_ready(ch)});
    @(posedge clk);
    model_step(rst_n, v, ch, md, p, d);
    @(negedge clk);
    chk("wave", {28'b0, wave}, {28'b0, e_wave});
    chk("period_tick", {28'b0, period_tick}, {28'b0, e_tick});
    chk("done", {28'b0, done}, {28'b0, e_done});
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, e_err});
    obs_wave = wave;
    obs_done = done;
    obs_err  = cfg_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] pat;
    int highs, dones, cnt;

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0);
    chk("rst_wave", {28'b0, wave}, 32'd0);
    chk("rst_ready", {31'b0, cfg_ready}, 32'd1);

    // ch0 SQUARE P=4 from OFF: 1100 repeating, first high 2 cycles later
    tick(1, 1, 0, 1, 4, 0);
    idle(1);
    chk("ch0_first_low", {31'b0, obs_wave[0]}, 32'd0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      pat = {pat[6:0], obs_wave[0]};
    end
    chk("ch0_square_pat", {24'b0, pat}, 32'h000000CC);

    // ch1 PWM P=10 d=3, then PWM P=6 d=6 while running at phase 4
    tick(1, 1, 1, 2, 10, 3);
    idle(5);
    tick(1, 1, 1, 2, 6, 6);
    // back-pressure: second ch1 transfer refused, ch2 accepted
    tick(1, 1, 1, 2, 5, 1);
    tick(1, 1, 2, 1, 6, 0);
    idle(4);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      highs += obs_wave[1];
    end
    chk("ch1_full_duty", highs, 12);

    // ch3 ONESHOT P=8 d=5
    tick(1, 1, 3, 3, 8, 5);
    highs = 0; dones = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      highs += obs_wave[3];
      dones += obs_done[3];
    end
    chk("ch3_oneshot_high", highs, 5);
    chk("ch3_oneshot_done", dones, 1);

    // out-of-range channel
    tick(1, 1, 5, 1, 3, 0);
    chk("err_pulse", {31'b0, obs_err}, 32'd1);
    idle(1);
    chk("err_single", {31'b0, obs_err}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit rn, v;
      rn = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 2) == 0);
      tick(rn, v, $urandom_range(0, 6), $urandom_range(0, 3),
           $urandom_range(0, 12), $urandom_range(0, 14));
    end

    // reset mid-period drops a pending update
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 1, 40, 0);
    idle(5);
    tick(1, 1, 0, 2, 6, 3);
    tick(0, 0, 0, 0, 0, 0);
    chk("midrst_wave", {28'b0, wave}, 32'd0);
    chk("midrst_tick", {28'b0, period_tick}, 32'd0);
    chk("midrst_ready", {31'b0, cfg_ready}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      cnt += obs_wave[0];
    end
    chk("midrst_no_apply", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
